// File: rtl/kgp_imem_loader.sv
// Boot-time program loader: assembles a length-prefixed, XOR-checksummed byte stream into
// big-endian 32-bit words, writes them to instruction BRAM and holds the CPU in reset until verified.
module kgp_imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {StLenHi, StLenLo, StData, StCheck, StDone, StError} state_e;

  localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [7:0]          csum_q, csum_d;
  logic [15:0]         words_q, words_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                ready_q, ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  assign xfer      = in_valid & ready_q;
  assign len_full  = {len_q[15:8], in_data};
  assign last_word = (words_q + 16'd1) == len_q;

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q <= StLenHi;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLenHi: if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (xfer) begin
          if ({1'b0, len_full} > MaxWords) state_d = StError;
          else if (len_full == 16'd0)      state_d = StCheck;
          else                             state_d = StData;
        end
      end
      StData:  if (xfer && byte_cnt_q == 2'd3 && last_word) state_d = StCheck;
      StCheck: if (xfer) state_d = (in_data == csum_q) ? StDone : StError;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    if (xfer) begin
      unique case (state_q)
        StLenHi: len_d[15:8] = in_data;
        StLenLo: len_d[7:0]  = in_data;
        StData: begin
          asm_d      = {asm_q[15:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address uses the pre-increment count; the write lands in the cycle it advances.
            we_d    = 1'b1;
            din_d   = {asm_q, in_data};
            addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(words_q);
            words_d = words_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
    ready_d   = (state_d != StDone) && (state_d != StError);
    cpu_rst_d = state_d != StDone;
    done_d    = state_d == StDone;
    err_d     = state_d == StError;
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      len_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      din_q      <= '0;
      ready_q    <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ready_q    <= ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_din     = din_q;
  assign cpu_reset    = cpu_rst_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_kgp_imem_loader.sv
// Scoreboard bench for kgp_imem_loader: expected writes are queued as bytes are accepted and
// checked (address, data, cycle) by a monitor when imem_we pulses.
module tb_kgp_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, cpu_reset, load_done, load_error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_din;
  logic [15:0] words_loaded;

  kgp_imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clka(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] din;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         cyc = 0;
  int         we_count = 0;
  int         errors = 0;
  int         checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write pulse must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      exp_t e;
      we_count = we_count + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write: addr=%0h din=%08h cyc=%0d, no write expected",
                 imem_addr, imem_din, cyc);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_din !== e.din || cyc !== e.cyc) begin
          errors = errors + 1;
          $display("FAIL write: addr=%0h din=%08h cyc=%0d, expected addr=%0h din=%08h cyc=%0d",
                   imem_addr, imem_din, cyc, e.addr, e.din, e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      errors++; checks++;
      $display("FAIL handshake: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends the first nbytes of tx_q; queues each word's write when its 4th byte is accepted.
  task automatic send_frame(input int nbytes, input int gap);
    int   n;
    exp_t e;
    n = {tx_q[0], tx_q[1]};
    for (int i = 0; i < nbytes; i++) begin
      send_byte(tx_q[i], gap);
      if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
        e.addr = 10'((i - 2) / 4);
        e.din  = {tx_q[i-3], tx_q[i-2], tx_q[i-1], tx_q[i]};
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_scenario1();
    tx_q = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20, 8'h93};
  endtask

  task automatic check_end(input string name, input logic done, input logic err,
                           input logic [15:0] words);
    checks++;
    if (load_done !== done || load_error !== err || cpu_reset !== !done ||
        in_ready !== 1'b0 || words_loaded !== words) begin
      errors++;
      $display("FAIL %s_end: done=%b err=%b cpu_rst=%b rdy=%b words=%0d, required %b %b %b 0 %0d",
               name, load_done, load_error, cpu_reset, in_ready, words_loaded,
               done, err, !done, words);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_din !== 32'd0 ||
        cpu_reset !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 ||
        words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b we=%b addr=%0h din=%08h cpu_rst=%b done=%b err=%b words=%0d",
               in_ready, imem_we, imem_addr, imem_din, cpu_reset, load_done, load_error,
               words_loaded);
    end
    in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    load_scenario1();
    send_frame(11, 0);
    check_end("basic", 1'b1, 1'b0, 16'd2);
    drain("basic");
  endtask

  task automatic test_bad_checksum();
    do_reset();
    load_scenario1();
    tx_q[10] = 8'h92;
    send_frame(11, 0);
    check_end("bad_csum", 1'b0, 1'b1, 16'd2);
    drain("bad_csum");
  endtask

  task automatic test_empty();
    int w0;
    do_reset();
    w0 = we_count;
    tx_q = '{8'h00, 8'h00, 8'h00};
    send_frame(3, 0);
    check_end("empty_ok", 1'b1, 1'b0, 16'd0);
    do_reset();
    tx_q = '{8'h00, 8'h00, 8'h01};
    send_frame(3, 0);
    check_end("empty_bad", 1'b0, 1'b1, 16'd0);
    drain("empty");
    checks++;
    if (we_count !== w0) begin
      errors++;
      $display("FAIL empty_writes: got %0d writes, required 0", we_count - w0);
    end
  endtask

  task automatic test_length_limit();
    int w0;
    do_reset();
    w0 = we_count;
    tx_q = '{8'h04, 8'h01};
    send_frame(2, 0);
    check_end("len_over", 1'b0, 1'b1, 16'd0);
    do_reset();
    tx_q = '{8'h04, 8'h00};
    send_frame(2, 0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (in_ready !== 1'b1 || load_error !== 1'b0 || load_done !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL len_max: rdy=%b err=%b done=%b cpu_rst=%b, required 1 0 0 1",
               in_ready, load_error, load_done, cpu_reset);
    end
    drain("len");
    checks++;
    if (we_count !== w0) begin
      errors++;
      $display("FAIL len_writes: got %0d writes, required 0", we_count - w0);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    load_scenario1();
    send_frame(11, 3);
    check_end("gaps", 1'b1, 1'b0, 16'd2);
    drain("gaps");
  endtask

  task automatic test_reset_midload();
    int w0;
    do_reset();
    w0 = we_count;
    load_scenario1();
    send_frame(6, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || words_loaded !== 16'd0 || we_count - w0 !== 1) begin
      errors++;
      $display("FAIL midreset: cpu_rst=%b words=%0d writes=%0d, required 1 0 1",
               cpu_reset, words_loaded, we_count - w0);
    end
    send_frame(11, 0);
    check_end("reload", 1'b1, 1'b0, 16'd2);
    drain("reload");
  endtask

  task automatic test_full_capacity();
    logic [7:0]  cs;
    logic [31:0] w;
    do_reset();
    tx_q = '{8'h04, 8'h00};
    cs = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      w = {16'(i), ~16'(i)} ^ 32'h5A3C_0000;
      for (int k = 3; k >= 0; k--) begin
        tx_q.push_back(w[k*8 +: 8]);
        cs ^= w[k*8 +: 8];
      end
    end
    tx_q.push_back(cs);
    send_frame(tx_q.size(), 0);
    check_end("full", 1'b1, 1'b0, 16'd1024);
    drain("full");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_empty();
    test_length_limit();
    test_gaps();
    test_reset_midload();
    test_full_capacity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kgp_imem_loader.md
Name: kgp_imem_loader

Overview:
- Boot-time program loader for KGP_RISC_Processor: the writer side of the processor's instruction-memory read port.
- Accepts a byte stream from a valid/ready source (e.g. a UART receiver), assembles 32-bit big-endian instruction words and writes them into instruction BRAM port A.
- Holds the processor in reset until a complete, checksum-verified program has been written.

Parameters:
ADDR_W, 10, instruction memory word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, word address of the first loaded instruction

Ports:
clka  input  1  system clock; all logic is rising-edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  source has a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  ADDR_W  instruction memory word address
imem_din  output  32  instruction word to write
cpu_reset  output  1  reset to the processor; high until the load completes successfully
load_done  output  1  program loaded and verified
load_error  output  1  load failed: bad length or checksum
words_loaded  output  16  count of words written so far

Behaviour:
- Interface: one clock, clka; reset is synchronous and active-high. All outputs are registered.
- Reset values: state=LEN_HI, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_din=0, cpu_reset=1, load_done=0, load_error=0, words_loaded=0, byte counter=0, checksum=0, length=0.
- in_ready is 1 in states LEN_HI, LEN_LO, DATA and CHECK, including the first cycle after reset deasserts. It is 0 in DONE and ERROR.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4N data bytes, then 1 checksum byte. The checksum is the XOR of all data bytes; the length bytes are excluded.
- LEN_HI: on transfer, latch the byte into N[15:8] and go to LEN_LO.
- LEN_LO: on transfer, latch the byte into N[7:0], then branch:
  - N > 2^ADDR_W: go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA:
  - Each transfer shifts the byte into a 32-bit assembly register, first byte landing in bits [31:24], and XORs it into the checksum.
  - On the 4th byte of a word: in the next cycle imem_we=1, imem_din=assembled word, imem_addr=BASE_ADDR+words_loaded (pre-increment value). In that same cycle words_loaded increments.
  - After the 4th byte of word N, go to CHECK.
- CHECK: on transfer, compare in_data with the checksum.
  - Equal: go to DONE; load_done=1 and cpu_reset=0 from the next cycle.
  - Unequal: go to ERROR; load_error=1 from the next cycle, cpu_reset stays 1.
- DONE and ERROR are terminal; only reset leaves them. Input bytes are ignored (in_ready=0).
- Latency: the imem_we pulse occurs exactly 1 cycle after the accepting edge of the word's last byte.
- Gaps in in_valid (any length) stall the FSM with no state change; imem_we is never asserted except as specified.
- imem_addr wraps modulo 2^ADDR_W. When N == 2^ADDR_W, the last word lands at BASE_ADDR-1 mod 2^ADDR_W.
- Reset mid-load: the FSM returns to LEN_HI and all counters and checksum clear. Words already written to memory are not erased. cpu_reset reasserts in the same cycle reset is sampled.
- When in_valid=0, in_data is ignored.

Test Plan:
1. Send stream 00 02 8C 01 00 04 00 22 18 20 93 continuously -> imem_we pulses twice: addr 0 din 0x8C010004, then addr 1 din 0x00221820. Afterwards words_loaded=2, load_done=1, cpu_reset=0, in_ready=0.
2. Same stream with checksum byte 0x92 -> both words are written, then load_error=1, load_done=0, cpu_reset stays 1.
3. Send 00 00 00 -> no imem_we pulse, load_done=1, cpu_reset=0. Send 00 00 01 -> load_error=1.
4. Send 04 01 with ADDR_W=10 -> load_error=1 the cycle after LEN_LO is accepted, no writes. Send 04 00 -> FSM enters DATA (in_ready=1, no error).
5. Repeat scenario 1 with 3 idle cycles of in_valid=0 between every byte -> identical writes and final state; each imem_we is exactly 1 cycle after the 4th byte of its word.
6. Scenario 1 with reset asserted for one cycle after the 6th byte, then the full scenario-1 stream resent -> first pass has already written addr 0; the reload rewrites addr 0 and addr 1 with the same values; ends with load_done=1 and words_loaded=2.
